// File: rtl/rr_arbiter_n_if.sv
// Request/grant bundle between a set of requesters and rr_arbiter_n.
// The requester side uses the master modport, the arbiter the slave modport.
interface rr_arbiter_n_if #(
    parameter int N = 4
) ();
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req;
    logic           ack;
    logic [N-1:0]   grant;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic           timeout;

    modport master (
        output req,
        output ack,
        input  grant,
        input  grant_valid,
        input  grant_id,
        input  timeout
    );

    modport slave (
        input  req,
        input  ack,
        output grant,
        output grant_valid,
        output grant_id,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter_n.sv
// N-way arbiter, round-robin or fixed priority, with a hold timeout.
// Grants are registered and change only on a release or an IDLE-to-GRANT step.
module rr_arbiter_n #(
    parameter int N       = 4,
    parameter int MODE    = 0,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter_n_if.slave bus
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;
    localparam logic [15:0] TO_LAST = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic           grant_valid_q, grant_valid_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic           timeout_q, timeout_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [15:0]    cnt_q, cnt_d;

    logic           owner_req;
    logic           rel_ack, rel_wd, rel_to, rel_any;
    logic [IDW-1:0] ptr_next, arb_ptr;
    logic [IDW-1:0] win_id;
    logic           win_found;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N) sum = sum - N;
        return IDW'(sum);
    endfunction

    // Release causes, ack first: ack masks both withdrawal and timeout.
    assign owner_req = bus.req[grant_id_q];
    assign rel_ack   = (state_q == GRANT) && bus.ack;
    assign rel_wd    = (state_q == GRANT) && !bus.ack && !owner_req;
    assign rel_to    = (TIMEOUT > 0) && (state_q == GRANT) && !bus.ack && owner_req
                       && (cnt_q == TO_LAST);
    assign rel_any   = rel_ack | rel_wd | rel_to;
    assign ptr_next  = wrap_add(grant_id_q, 1);
    assign arb_ptr   = rel_any ? ptr_next : ptr_q;

    // The advanced pointer already scans the released requester last, so it
    // only wins the same-edge decision again when it is the sole requester.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (MODE == 1) begin
                if (bus.req[i]) begin
                    win_found = 1'b1;
                    win_id    = IDW'(i);
                end
            end else if (bus.req[wrap_add(arb_ptr, i)]) begin
                win_found = 1'b1;
                win_id    = wrap_add(arb_ptr, i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        timeout_d     = 1'b0;

        if ((state_q == IDLE) || rel_any) begin
            if (rel_any) begin
                ptr_d     = ptr_next;
                timeout_d = rel_to;
            end
            cnt_d = 16'd0;
            if (win_found) begin
                state_d       = GRANT;
                grant_d       = N'(1) << win_id;
                grant_valid_d = 1'b1;
                grant_id_d    = win_id;
            end else begin
                state_d       = IDLE;
                grant_d       = '0;
                grant_valid_d = 1'b0;
                grant_id_d    = '0;
            end
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            timeout_q     <= 1'b0;
            ptr_q         <= '0;
            cnt_q         <= 16'd0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            timeout_q     <= timeout_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_rr_arbiter_n.sv
// Bench for rr_arbiter_n: a round-robin and a fixed-priority instance share
// stimulus and are compared with constant vectors and a reference model.
module tb_rr_arbiter_n;
    localparam int N  = 4;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    rr_arbiter_n_if #(.N(N)) bus0 ();
    rr_arbiter_n_if #(.N(N)) bus1 ();

    rr_arbiter_n #(.N(N), .MODE(0), .TIMEOUT(TO)) u_rr (.clk(clk), .rst(rst), .bus(bus0));
    rr_arbiter_n #(.N(N), .MODE(1), .TIMEOUT(TO)) u_fp (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    // Reference model: index 0 is round-robin, index 1 is fixed priority.
    // m_age counts how many cycles the current grant has been visible.
    bit m_busy[2];
    int m_owner[2];
    int m_ptr[2];
    int m_age[2];
    bit m_to[2];

    typedef struct {
        logic [N-1:0] req;
        logic         ack;
        logic [N-1:0] g_rr;
        logic [N-1:0] g_fp;
        logic         to;
    } vec_t;

    vec_t vecs[9];

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            m_busy[m]  = 1'b0;
            m_owner[m] = 0;
            m_ptr[m]   = 0;
            m_age[m]   = 0;
            m_to[m]    = 1'b0;
        end
    endtask

    task automatic modelStep(input logic [N-1:0] r, input logic a);
        for (int m = 0; m < 2; m++) begin
            bit freed;
            freed   = 1'b0;
            m_to[m] = 1'b0;
            if (m_busy[m]) begin
                if (a) freed = 1'b1;
                else if (!r[m_owner[m]]) freed = 1'b1;
                else if (TO > 0 && m_age[m] == TO) begin
                    freed   = 1'b1;
                    m_to[m] = 1'b1;
                end else m_age[m] = m_age[m] + 1;
                if (freed) begin
                    m_ptr[m]  = (m_owner[m] + 1) % N;
                    m_busy[m] = 1'b0;
                end
            end
            if (!m_busy[m]) begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m == 0) ? (m_ptr[m] + k) % N : k;
                    if (r[idx] && !m_busy[m]) begin
                        m_busy[m]  = 1'b1;
                        m_owner[m] = idx;
                        m_age[m]   = 1;
                    end
                end
            end
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOne(input string tag, input int m, input logic [N-1:0] g,
                            input logic v, input logic [1:0] id, input logic t);
        logic [N-1:0] eg;
        eg = m_busy[m] ? (N'(1) << m_owner[m]) : '0;
        cmp($sformatf("%s m%0d grant", tag, m), 32'(g), 32'(eg));
        cmp($sformatf("%s m%0d valid", tag, m), 32'(v), 32'(m_busy[m]));
        cmp($sformatf("%s m%0d id", tag, m), 32'(id), m_busy[m] ? m_owner[m] : 0);
        cmp($sformatf("%s m%0d timeout", tag, m), 32'(t), 32'(m_to[m]));
    endtask

    task automatic checkOutput(input string tag);
        checkOne(tag, 0, bus0.grant, bus0.grant_valid, bus0.grant_id, bus0.timeout);
        checkOne(tag, 1, bus1.grant, bus1.grant_valid, bus1.grant_id, bus1.timeout);
        cmp($sformatf("%s rr ptr", tag), 32'(u_rr.ptr_q), m_ptr[0]);
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic a);
        bus0.req = r;
        bus1.req = r;
        bus0.ack = a;
        bus1.ack = a;
        @(posedge clk);
        modelStep(r, a);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b0;
        bus0.req = '0; bus1.req = '0;
        bus0.ack = 1'b0; bus1.ack = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        rst = 1'b1;
    endtask

    initial begin
        logic [N-1:0] r;
        logic         a;

        vecs[0] = '{4'b1111, 1'b0, 4'b0001, 4'b0001, 1'b0};
        vecs[1] = '{4'b1111, 1'b1, 4'b0010, 4'b0001, 1'b0};
        vecs[2] = '{4'b1111, 1'b1, 4'b0100, 4'b0001, 1'b0};
        vecs[3] = '{4'b1111, 1'b1, 4'b1000, 4'b0001, 1'b0};
        vecs[4] = '{4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b0};
        vecs[5] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};
        vecs[6] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0};
        vecs[7] = '{4'b1111, 1'b0, 4'b0010, 4'b0001, 1'b0};
        vecs[8] = '{4'b1010, 1'b1, 4'b1000, 4'b0010, 1'b0};

        $display("[TB] vector table");
        doReset();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].req, vecs[i].ack);
            cmp($sformatf("vec%0d rr grant", i), 32'(bus0.grant), 32'(vecs[i].g_rr));
            cmp($sformatf("vec%0d fp grant", i), 32'(bus1.grant), 32'(vecs[i].g_fp));
            cmp($sformatf("vec%0d timeout", i), 32'(bus0.timeout), 32'(vecs[i].to));
            checkOutput($sformatf("vec%0d", i));
        end

        // Timeout on a held request, re-granted on the release edge.
        $display("[TB] timeout sequence");
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0100, 1'b0);
            cmp($sformatf("hold%0d grant", i), 32'(bus0.grant), 32'h4);
            cmp($sformatf("hold%0d timeout", i), 32'(bus0.timeout), 32'h0);
            checkOutput($sformatf("hold%0d", i));
        end
        applyStimulus(4'b0100, 1'b0);
        cmp("to pulse", 32'(bus0.timeout), 32'h1);
        cmp("to fp pulse", 32'(bus1.timeout), 32'h1);
        cmp("to regrant", 32'(bus0.grant), 32'h4);
        cmp("to ptr", 32'(u_rr.ptr_q), 32'd3);
        checkOutput("to");
        applyStimulus(4'b0100, 1'b0);
        cmp("to pulse end", 32'(bus0.timeout), 32'h0);
        checkOutput("to+1");

        // Withdrawal from requester 3 with the pointer wrapping to 0.
        $display("[TB] withdrawal wrap");
        doReset();
        applyStimulus(4'b1000, 1'b0);
        cmp("wd first", 32'(bus0.grant), 32'h8);
        applyStimulus(4'b0001, 1'b0);
        cmp("wd grant", 32'(bus0.grant), 32'h1);
        cmp("wd ptr", 32'(u_rr.ptr_q), 32'd0);
        cmp("wd timeout", 32'(bus0.timeout), 32'h0);
        checkOutput("wd");

        // Ack arriving on the last allowed hold cycle wins over timeout.
        $display("[TB] ack versus timeout");
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(4'b0010, 1'b0);
        applyStimulus(4'b0010, 1'b1);
        cmp("col timeout", 32'(bus0.timeout), 32'h0);
        cmp("col fp timeout", 32'(bus1.timeout), 32'h0);
        cmp("col ptr", 32'(u_rr.ptr_q), 32'd2);
        checkOutput("col");

        // Asynchronous reset between edges while a grant is held.
        $display("[TB] async reset mid-grant");
        doReset();
        applyStimulus(4'b0010, 1'b0);
        cmp("ar pre grant", 32'(bus0.grant), 32'h2);
        #3;
        rst = 1'b0;
        modelReset();
        #1;
        cmp("ar rr grant", 32'(bus0.grant), 32'h0);
        cmp("ar fp grant", 32'(bus1.grant), 32'h0);
        cmp("ar timeout", 32'(bus0.timeout), 32'h0);
        checkOutput("ar");
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(4'b1111, 1'b0);
        cmp("ar regrant", 32'(bus0.grant), 32'h1);
        checkOutput("ar+1");

        // Random traffic with sticky requests so holds reach the timeout.
        $display("[TB] random traffic");
        doReset();
        r = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, 15));
            a = ($urandom_range(0, 4) == 0);
            applyStimulus(r, a);
            checkOutput($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
